kernel_seq_ctrl: RTL and testbench
==================================

# kernel_seq_ctrl

Sequencer for the AdderNet kernel datapath. Given a job of `i_nout` output channels, each reducing `i_nchunk` chunks of `NDATA` feature/weight pairs, it generates feature-buffer and weight-buffer read addresses, one chunk per cycle. It also tracks the fixed datapath latency: buffer read, kernel DFF stage, then adder tree. From that it drives the accumulator controls and the per-output valid strobe. It sits between the layer controller (start/base/count) and the buffers, the kernel register stage and the accumulator.

## Interface
Parameters:
- `ADDR_W`, 10: buffer address width.
- `NCHUNK_W`, 8: width of chunk count.
- `NOUT_W`, 12: width of output count.
- `LAT`, 3: cycles from `o_rd_en` to the matching `o_acc_en`; must be ≥ 1.

Ports:
- `CLK` input 1: single clock, rising edge.
- `RSTN` input 1: asynchronous active-low reset.
- `i_start` input 1: job start pulse; sampled only in IDLE.
- `i_nchunk` input NCHUNK_W: chunks per output; latched at start.
- `i_nout` input NOUT_W: outputs per job; latched at start.
- `i_if_base` input ADDR_W: feature base address; latched at start.
- `i_w_base` input ADDR_W: weight base address; latched at start.
- `i_hold` input 1: suppresses new issue in the current cycle.
- `o_busy` output 1: job in progress.
- `o_rd_en` output 1: buffer read strobe, one chunk.
- `o_if_addr` output ADDR_W: feature read address.
- `o_w_addr` output ADDR_W: weight read address.
- `o_acc_en` output 1: accumulator update enable.
- `o_acc_clr` output 1: with `o_acc_en`, load instead of add (first chunk).
- `o_out_valid` output 1: accumulator holds a finished output.
- `o_done` output 1: one-cycle job-complete pulse.

## Operation
- States are IDLE, ISSUE, DRAIN.
- IDLE → ISSUE on `i_start`=1 when `i_nchunk`≠0 and `i_nout`≠0. Counts and bases are latched, and chunk counter c = 0 and output counter o = 0.
- IDLE with `i_start`=1 and either count = 0: the block pulses `o_busy` for one cycle, pulses `o_done` in the same cycle, issues no reads, and returns to IDLE.
- ISSUE, each cycle with `i_hold`=0:
  - `o_rd_en`=1, `o_if_addr` = if_base + c, `o_w_addr` = w_base + o·nchunk + c.
  - The weight address is a running pointer incremented by 1; the feature address restarts at if_base for every output.
  - c increments; at c = nchunk−1, c → 0 and o increments.
  - After issuing chunk nchunk−1 of output nout−1, the state goes to DRAIN.
- ISSUE with `i_hold`=1: `o_rd_en`=0, counters and addresses are frozen, and the in-flight pipeline keeps advancing.
- Tag delay line, `LAT` stages: each issue pushes {valid, first=(c==0), last=(c==nchunk−1), final=last output}.
  - At the tail of the delay line, `o_acc_en`=valid and `o_acc_clr`=valid&first.
  - A tail tag with last=1 sets `o_out_valid` in the following cycle.
- DRAIN: wait until the delay line is empty and the final `o_out_valid` has been produced.
  - `o_done` pulses in the same cycle as the final `o_out_valid`.
  - IDLE is entered on the next cycle, where `o_busy`=0.
- `i_start` while busy is ignored; there is no abort except `RSTN`.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- o·nchunk is never multiplied; it is held as the incremented pointer.

## Timing
- Reset: all outputs 0, state IDLE, delay line cleared. Reset takes effect immediately and asynchronously, including mid-job. In-flight tags are discarded, and no `o_done` is produced for the aborted job.
- All outputs are registered.
- `i_start` sampled at edge k gives the first `o_rd_en` in cycle k+1, and `o_busy`=1 from cycle k+1.
- With no holds, chunk c of output o is issued in cycle k+1+o·N+c, where N = nchunk.
- `o_acc_en` follows its `o_rd_en` by exactly `LAT` cycles.
- `o_out_valid` follows the last chunk's `o_acc_en` by 1 cycle.
- Hold cycles delay issue one-for-one. The delay line does not stall, so `o_acc_en` may show gaps.
- Back-to-back jobs: a new `i_start` is accepted in the first IDLE cycle after `o_done`.

## Test plan
- LAT=3, nchunk=4, nout=2, if_base=0x010, w_base=0x100, start at cycle 0:
  - `o_rd_en` in cycles 1–8; if_addr 0x010–0x013 twice; w_addr 0x100–0x107.
  - `o_acc_clr` in cycles 4 and 8; `o_acc_en` in cycles 4–11.
  - `o_out_valid` in cycles 8 and 12; `o_done` in cycle 12; `o_busy` low from cycle 13.
- Same job with `i_hold`=1 in cycles 2–3: issue stalls with addresses frozen at 0x011/0x101; every later event shifts by 2 (done at 14); no read is duplicated or skipped.
- nchunk=1, nout=3: each issue carries both clr and last, giving `o_out_valid` in cycles 5, 6, 7 and `o_done` in cycle 7.
- nchunk=0: `o_busy` and `o_done` are high only in cycle 1, with no `o_rd_en` or `o_acc_en`.
- `i_start` re-pulsed at cycle 3 of a running job: it is ignored and the counts and bases are unchanged. w_base=0x3FE with ADDR_W=10 wraps to 0x000 and 0x001.
- `RSTN` low at cycle 5 mid-job: all outputs are 0 in the same cycle, with no later acc or done pulses. A restart after release behaves exactly as the first scenario.

Source files
------------

// File: rtl/kernel_seq_ctrl.sv
// kernel_seq_ctrl: address and latency sequencer for the AdderNet kernel datapath.
// Issues one chunk read per cycle (feature/weight addresses), carries a tag for
// every issue through a LAT-deep delay line, and turns the tail tags into the
// accumulator load/add enables, per-output valid strobes and job completion.
module kernel_seq_ctrl #(
   parameter int ADDR_W   = 10,
   parameter int NCHUNK_W = 8,
   parameter int NOUT_W   = 12,
   parameter int LAT      = 3
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                i_start,
   input  logic [NCHUNK_W-1:0] i_nchunk,
   input  logic [NOUT_W-1:0]   i_nout,
   input  logic [ADDR_W-1:0]   i_if_base,
   input  logic [ADDR_W-1:0]   i_w_base,
   input  logic                i_hold,
   output logic                o_busy,
   output logic                o_rd_en,
   output logic [ADDR_W-1:0]   o_if_addr,
   output logic [ADDR_W-1:0]   o_w_addr,
   output logic                o_acc_en,
   output logic                o_acc_clr,
   output logic                o_out_valid,
   output logic                o_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // Tag bit positions: {valid, first chunk, last chunk, final output}
   localparam int TAG_V = 3;
   localparam int TAG_F = 2;
   localparam int TAG_L = 1;
   localparam int TAG_X = 0;

   state_t                   r_state;
   logic [NCHUNK_W-1:0]      r_nchunk;
   logic [NOUT_W-1:0]        r_nout;
   logic [ADDR_W-1:0]        r_if_base;
   logic [NCHUNK_W-1:0]      r_c;
   logic [NOUT_W-1:0]        r_o;
   logic [ADDR_W-1:0]        r_w_ptr;
   logic [LAT-1:0][3:0]      r_tag;
   logic                     r_acc_last;
   logic                     r_acc_final;

   logic                     w_idle_start;
   logic                     w_nonzero;
   logic                     w_issue;
   logic [NCHUNK_W-1:0]      w_nchunk;
   logic [NOUT_W-1:0]        w_nout;
   logic [NCHUNK_W-1:0]      w_c;
   logic [NOUT_W-1:0]        w_o;
   logic [ADDR_W-1:0]        w_if_addr;
   logic [ADDR_W-1:0]        w_w_addr;
   logic                     w_last_c;
   logic                     w_last_o;
   logic                     w_final;

   function automatic logic [3:0] f_make_tag(input logic v, input logic first,
                                             input logic last, input logic fin);
      return {v, first, last, fin};
   endfunction

   // Select the chunk about to be issued: the start edge issues chunk 0 straight
   // from the inputs, later edges issue from the latched job and counters.
   always_comb begin
      w_idle_start = (r_state == S_IDLE) && !o_busy && i_start;
      w_nonzero    = (i_nchunk != {NCHUNK_W{1'b0}}) && (i_nout != {NOUT_W{1'b0}});
      if (r_state == S_IDLE) begin
         w_nchunk  = i_nchunk;
         w_nout    = i_nout;
         w_c       = {NCHUNK_W{1'b0}};
         w_o       = {NOUT_W{1'b0}};
         w_if_addr = i_if_base;
         w_w_addr  = i_w_base;
      end else begin
         w_nchunk  = r_nchunk;
         w_nout    = r_nout;
         w_c       = r_c;
         w_o       = r_o;
         w_if_addr = r_if_base + ADDR_W'(r_c);
         w_w_addr  = r_w_ptr;
      end
      w_issue  = (w_idle_start && w_nonzero) || ((r_state == S_ISSUE) && !i_hold);
      w_last_c = (w_c == (w_nchunk - NCHUNK_W'(1'b1)));
      w_last_o = (w_o == (w_nout - NOUT_W'(1'b1)));
      w_final  = w_last_c && w_last_o;
   end

   // Job FSM: latches the job, advances chunk/output counters and the running
   // weight pointer, registers the read strobe/addresses, busy and done.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state   <= S_IDLE;
         r_nchunk  <= {NCHUNK_W{1'b0}};
         r_nout    <= {NOUT_W{1'b0}};
         r_if_base <= {ADDR_W{1'b0}};
         r_c       <= {NCHUNK_W{1'b0}};
         r_o       <= {NOUT_W{1'b0}};
         r_w_ptr   <= {ADDR_W{1'b0}};
         o_busy    <= 1'b0;
         o_rd_en   <= 1'b0;
         o_if_addr <= {ADDR_W{1'b0}};
         o_w_addr  <= {ADDR_W{1'b0}};
         o_done    <= 1'b0;
      end else begin
         o_rd_en <= w_issue;
         o_done  <= (w_idle_start && !w_nonzero) ||
                    (o_acc_en && r_acc_last && r_acc_final);
         if (w_issue) begin
            o_if_addr <= w_if_addr;
            o_w_addr  <= w_w_addr;
            r_w_ptr   <= w_w_addr + ADDR_W'(1'b1);
            if (w_last_c) begin
               r_c <= {NCHUNK_W{1'b0}};
               r_o <= w_o + NOUT_W'(1'b1);
            end else begin
               r_c <= w_c + NCHUNK_W'(1'b1);
               r_o <= w_o;
            end
         end else begin
            o_if_addr <= o_if_addr;
            o_w_addr  <= o_w_addr;
         end
         case (r_state)
            S_IDLE: begin
               if (w_idle_start) begin
                  r_nchunk  <= i_nchunk;
                  r_nout    <= i_nout;
                  r_if_base <= i_if_base;
                  o_busy    <= 1'b1;
                  if (!w_nonzero) begin
                     r_state <= S_IDLE;
                  end else if (w_final) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end else begin
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_ISSUE: begin
               o_busy <= 1'b1;
               if (w_issue && w_final) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_state <= S_ISSUE;
               end
            end
            S_DRAIN: begin
               if (o_done) begin
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  o_busy  <= 1'b1;
                  r_state <= S_DRAIN;
               end
            end
            default: begin
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Tag delay line and its tail decode; it never stalls, so holds show up as
   // gaps in the accumulator enables rather than as frozen pipeline stages.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_tag       <= {(LAT*4){1'b0}};
         o_acc_en    <= 1'b0;
         o_acc_clr   <= 1'b0;
         r_acc_last  <= 1'b0;
         r_acc_final <= 1'b0;
         o_out_valid <= 1'b0;
      end else begin
         if (w_issue) begin
            r_tag[0] <= f_make_tag(1'b1, (w_c == {NCHUNK_W{1'b0}}), w_last_c, w_final);
         end else begin
            r_tag[0] <= 4'b0000;
         end
         for (int i = 1; i < LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
         o_acc_en    <= r_tag[LAT-1][TAG_V];
         o_acc_clr   <= r_tag[LAT-1][TAG_V] & r_tag[LAT-1][TAG_F];
         r_acc_last  <= r_tag[LAT-1][TAG_V] & r_tag[LAT-1][TAG_L];
         r_acc_final <= r_tag[LAT-1][TAG_V] & r_tag[LAT-1][TAG_L] & r_tag[LAT-1][TAG_X];
         o_out_valid <= o_acc_en & r_acc_last;
      end
   end

endmodule

// File: tb/tb_kernel_seq_ctrl.sv
// Bench for kernel_seq_ctrl: an event-schedule model predicts every output per
// cycle for each job; one negedge process compares the DUT against it.
module tb_kernel_seq_ctrl;
   localparam int ADDR_W   = 10;
   localparam int NCHUNK_W = 8;
   localparam int NOUT_W   = 12;
   localparam int LAT      = 3;
   localparam int NCYC     = 128;

   logic                CLK = 1'b0;
   logic                RSTN = 1'b0;
   logic                i_start = 1'b0;
   logic [NCHUNK_W-1:0] i_nchunk = '0;
   logic [NOUT_W-1:0]   i_nout = '0;
   logic [ADDR_W-1:0]   i_if_base = '0;
   logic [ADDR_W-1:0]   i_w_base = '0;
   logic                i_hold = 1'b0;
   logic                o_busy, o_rd_en, o_acc_en, o_acc_clr, o_out_valid, o_done;
   logic [ADDR_W-1:0]   o_if_addr, o_w_addr;

   kernel_seq_ctrl #(.ADDR_W(ADDR_W), .NCHUNK_W(NCHUNK_W), .NOUT_W(NOUT_W), .LAT(LAT)) dut (
      .CLK(CLK), .RSTN(RSTN), .i_start(i_start), .i_nchunk(i_nchunk), .i_nout(i_nout),
      .i_if_base(i_if_base), .i_w_base(i_w_base), .i_hold(i_hold),
      .o_busy(o_busy), .o_rd_en(o_rd_en), .o_if_addr(o_if_addr), .o_w_addr(o_w_addr),
      .o_acc_en(o_acc_en), .o_acc_clr(o_acc_clr), .o_out_valid(o_out_valid), .o_done(o_done)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // expected outputs per absolute cycle
   bit       e_busy [NCYC];
   bit       e_rd   [NCYC];
   bit       e_acc  [NCYC];
   bit       e_clr  [NCYC];
   bit       e_ov   [NCYC];
   bit       e_done [NCYC];
   bit       e_ca   [NCYC];   // address outputs are checked this cycle
   int       e_if   [NCYC];
   int       e_w    [NCYC];
   bit       hold_m [NCYC];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int c, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, c, act, exp);
      end
   endtask

   // Schedule a job started (i_start high) in cycle s: chunk reads in order,
   // skipping cycles whose predecessor had hold high, each followed by its
   // accumulate LAT cycles later and, for a last chunk, a valid one cycle after.
   task automatic model_job(input int s, input int n, input int m, input int ifb,
                            input int wb, output int done_c);
      int t, idx, last_if, last_w;
      if (n == 0 || m == 0) begin
         e_busy[s+1] = 1'b1;
         e_done[s+1] = 1'b1;
         done_c = s + 1;
         return;
      end
      t = s + 1; idx = 0; last_if = 0; last_w = 0;
      for (int o = 0; o < m; o++) begin
         for (int c = 0; c < n; c++) begin
            if (idx != 0) begin
               while (hold_m[t-1]) begin
                  e_ca[t] = 1'b1; e_if[t] = last_if; e_w[t] = last_w;
                  t++;
               end
            end
            last_if = (ifb + c) % (1 << ADDR_W);
            last_w  = (wb + idx) % (1 << ADDR_W);
            e_rd[t] = 1'b1; e_ca[t] = 1'b1; e_if[t] = last_if; e_w[t] = last_w;
            e_acc[t+LAT] = 1'b1;
            if (c == 0) e_clr[t+LAT] = 1'b1;
            if (c == n - 1) e_ov[t+LAT+1] = 1'b1;
            idx++;
            t++;
         end
      end
      done_c = (t - 1) + LAT + 1;
      e_done[done_c] = 1'b1;
      for (int k = s + 1; k <= done_c; k++) e_busy[k] = 1'b1;
   endtask

   // Reset wipes everything from cycle 'from'; addresses read back as zero
   // until cycle 'ca_to'.
   task automatic model_abort(input int from, input int ca_to);
      for (int k = from; k < NCYC; k++) begin
         e_busy[k] = 1'b0; e_rd[k] = 1'b0; e_acc[k] = 1'b0; e_clr[k] = 1'b0;
         e_ov[k] = 1'b0; e_done[k] = 1'b0;
         e_ca[k] = (k <= ca_to); e_if[k] = 0; e_w[k] = 0;
      end
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic run_start(input int s, input int n, input int m, input int ifb, input int wb);
      goto(s);
      i_nchunk  = NCHUNK_W'(n);
      i_nout    = NOUT_W'(m);
      i_if_base = ADDR_W'(ifb);
      i_w_base  = ADDR_W'(wb);
      i_start   = 1'b1;
      goto(s + 1);
      i_start   = 1'b0;
   endtask

   // per-cycle compare against the model
   always @(negedge CLK) begin
      if (cyc < NCYC) begin
         chk("busy",      cyc, int'(o_busy),      int'(e_busy[cyc]));
         chk("rd_en",     cyc, int'(o_rd_en),     int'(e_rd[cyc]));
         chk("acc_en",    cyc, int'(o_acc_en),    int'(e_acc[cyc]));
         chk("acc_clr",   cyc, int'(o_acc_clr),   int'(e_clr[cyc]));
         chk("out_valid", cyc, int'(o_out_valid), int'(e_ov[cyc]));
         chk("done",      cyc, int'(o_done),      int'(e_done[cyc]));
         if (e_ca[cyc]) begin
            chk("if_addr", cyc, int'(o_if_addr), e_if[cyc]);
            chk("w_addr",  cyc, int'(o_w_addr),  e_w[cyc]);
         end
      end
   end

   initial begin
      int d1, d2, d3, d4, d4b, d5, d6, d7, d8;
      hold_m[32] = 1'b1;
      hold_m[33] = 1'b1;
      model_job(10,  4, 2, 'h010, 'h100, d1);
      model_job(30,  4, 2, 'h010, 'h100, d2);
      model_job(50,  1, 3, 'h020, 'h200, d3);
      model_job(60,  0, 5, 'h030, 'h300, d4);
      model_job(63,  3, 0, 'h030, 'h300, d4b);
      model_job(70,  2, 2, 'h200, 'h3FE, d5);
      model_job(79,  3, 1, 'h3FF, 'h010, d6);
      model_job(90,  4, 2, 'h010, 'h100, d7);
      model_abort(95, 100);
      model_job(100, 4, 2, 'h010, 'h100, d8);

      // hand-computed pins on the model
      chk("pin_done_s1",   0, d1, 22);
      chk("pin_w_last_s1", 0, e_w[18], 'h107);
      chk("pin_clr_s1",    0, int'(e_clr[14]) + int'(e_clr[18]) + int'(e_clr[15]), 2);
      chk("pin_ov_s1",     0, int'(e_ov[18]) + int'(e_ov[22]), 2);
      chk("pin_done_hold", 0, d2, 44);
      chk("pin_frz_hold",  0, e_if[34], 'h011);
      chk("pin_done_nc1",  0, d3, 57);
      chk("pin_zero_job",  0, d4, 61);
      chk("pin_w_wrap",    0, e_w[73], 'h000);
      chk("pin_if_wrap",   0, e_if[81], 'h000);
      chk("pin_done_rst",  0, d8, 112);

      goto(2);
      RSTN = 1'b1;
      run_start(10, 4, 2, 'h010, 'h100);
      run_start(30, 4, 2, 'h010, 'h100);
      goto(32); i_hold = 1'b1;
      goto(34); i_hold = 1'b0;
      run_start(50, 1, 3, 'h020, 'h200);
      run_start(60, 0, 5, 'h030, 'h300);
      run_start(63, 3, 0, 'h030, 'h300);
      run_start(70, 2, 2, 'h200, 'h3FE);
      run_start(73, 7, 9, 'h055, 'h066);   // ignored while busy
      run_start(79, 3, 1, 'h3FF, 'h010);
      run_start(90, 4, 2, 'h010, 'h100);
      goto(95);
      #1 RSTN = 1'b0;
      goto(97);
      RSTN = 1'b1;
      run_start(100, 4, 2, 'h010, 'h100);
      goto(120);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
